intdecl_gen: RTL and testbench
==============================

// Module: intdecl_gen
// PURPOSE
//  Transmit-side counterpart of the int-declaration checker. It emits a well-formed
//  C declaration "int v0,v1,...,vN-1;" as an ASCII byte stream, one char per
//  handshake, driving the checker's 8-bit char input in closed-loop self-checks.
//  Sits between a bench/controller (start, nvars) and any char-stream consumer.
// PARAMETERS
//  MAX_VARS    16    largest accepted identifier count (1..99)
//  SEP_SPACES  1     number of ' ' (8'h20) chars emitted after "int" (>=1)
//  PREFIX      "v"   8-bit ASCII leading letter of every identifier
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  start      in   1  request one declaration; sampled only in IDLE
//  nvars      in   7  identifier count, sampled with start
//  out_char   out  8  ASCII char presented to consumer
//  out_valid  out  1  out_char is valid
//  out_ready  in   1  consumer accepts out_char this cycle
//  busy       out  1  high from accepted start until final ';' transfers
//  done       out  1  1-cycle pulse the cycle after ';' transfers
//  err        out  1  1-cycle pulse: start with nvars==0 or nvars>MAX_VARS
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; out_char=8'h00, out_valid=0,
//    busy=0, done=0, err=0, counters cleared. Reset mid-stream aborts silently.
//  - Transfer occurs on a rising edge with out_valid&&out_ready. While
//    out_valid&&!out_ready, out_char holds; out_valid never drops before transfer.
//  - IDLE: start && 1<=nvars<=MAX_VARS -> latch nvars, busy=1, idx=0, go KW_I;
//    first char valid the next cycle (1-cycle latency). Bad nvars -> err pulse
//    next cycle, stay IDLE, no chars. start outside IDLE ignored.
//  - FSM; each state advances only on a transfer:
//    KW_I 'i' -> KW_N 'n' -> KW_T 't' -> SPC ' ' (repeat SEP_SPACES times) -> PFX
//    PFX PREFIX -> TENS if idx>=10 else ONES
//    TENS ASCII('0'+idx/10) -> ONES
//    ONES ASCII('0'+idx%10) -> COMMA if idx<nvars-1 else SEMI
//    COMMA ',' -> idx++, PFX
//    SEMI ';' -> IDLE; busy=0 on same edge; done=1 following cycle
//  - Indices decimal, no leading zero (v9,v10). idx 7-bit, never wraps.
//  - Stream length = 3+SEP_SPACES+sum(chars per id)+(nvars-1)+1.
//  - out_valid=1 in every non-IDLE state; busy==out_valid except on done cycle.
//  - start on the same cycle as done is accepted (back-to-back declarations).
// TESTING
//  1 nvars=3, ready=1 always -> "int v0,v1,v2;" 13 chars, one per cycle,
//    first 1 cycle after start; done once after ';'.
//  2 nvars=12, ready toggled 1/0 -> ids v0..v11, v10/v11 as 'v','1','0'; out_char
//    stable on every ready=0 cycle; no char duplicated or lost.
//  3 nvars=0, then nvars=MAX_VARS+1 -> err pulse each, out_valid stays 0, busy 0.
//  4 nvars=1, SEP_SPACES=3 -> "int   v0;" (9 chars); start pulsed while busy is ignored.
//  5 reset=0 mid-stream after "int v" -> out_valid, busy drop immediately; no done;
//    next start emits the full declaration from 'i'.
//  6 loop to checker: stream for nvars=1..MAX_VARS -> checker out=1 after every ';'.

Source files
------------

// File: rtl/intdecl_gen.sv
// -----------------------------------------------------------------------------
// intdecl_gen
//
// Emits the ASCII byte stream of a C declaration "int v0,v1,...,vN-1;", one
// character per valid/ready handshake. The stream is used to drive a
// character-stream consumer, such as the int-declaration checker, in
// closed-loop tests.
//
// Parameters
//   MAX_VARS    largest accepted identifier count (1..99)
//   SEP_SPACES  number of ' ' characters emitted after "int" (>= 1)
//   PREFIX      leading ASCII letter of every identifier
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   start      in   request one declaration; sampled only while idle
//   nvars      in   identifier count, sampled together with start
//   out_char   out  ASCII character presented to the consumer
//   out_valid  out  out_char is valid
//   out_ready  in   consumer accepts out_char this cycle
//   busy       out  high from the accepted start until the final ';' transfers
//   done       out  1-cycle pulse in the cycle after ';' transfers
//   err        out  1-cycle pulse after a start with nvars == 0 or nvars > MAX_VARS
// -----------------------------------------------------------------------------
module intdecl_gen #(
    parameter int         MAX_VARS   = 16,
    parameter int         SEP_SPACES = 1,
    parameter logic [7:0] PREFIX     = "v"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] nvars,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_KW_I  = 4'd1;
    localparam logic [3:0] S_KW_N  = 4'd2;
    localparam logic [3:0] S_KW_T  = 4'd3;
    localparam logic [3:0] S_SPC   = 4'd4;
    localparam logic [3:0] S_PFX   = 4'd5;
    localparam logic [3:0] S_TENS  = 4'd6;
    localparam logic [3:0] S_ONES  = 4'd7;
    localparam logic [3:0] S_COMMA = 4'd8;
    localparam logic [3:0] S_SEMI  = 4'd9;

    localparam int               SPC_W    = (SEP_SPACES > 1) ? $clog2(SEP_SPACES) : 1;
    localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(SEP_SPACES - 1);
    localparam logic [6:0]       MAX_V7   = 7'(MAX_VARS);

    logic [3:0]       state_q, state_d;
    logic [6:0]       nvars_q, nvars_d;
    logic [6:0]       idx_q,   idx_d;
    // Decimal digits of idx_q, kept alongside the binary index so that no
    // divider is needed to print the identifier number.
    logic [3:0]       tens_q,  tens_d;
    logic [3:0]       ones_q,  ones_d;
    logic [SPC_W-1:0] spc_q,   spc_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic xfer;
    logic last_id;

    assign xfer    = out_valid && out_ready;
    assign last_id = (idx_q == (nvars_q - 7'd1));

    always_comb begin
        state_d = state_q;
        nvars_d = nvars_q;
        idx_d   = idx_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        spc_d   = spc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((nvars == 7'd0) || (nvars > MAX_V7)) begin
                        err_d = 1'b1;
                    end else begin
                        nvars_d = nvars;
                        idx_d   = 7'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        spc_d   = '0;
                        state_d = S_KW_I;
                    end
                end
            end
            S_KW_I: if (xfer) state_d = S_KW_N;
            S_KW_N: if (xfer) state_d = S_KW_T;
            S_KW_T: if (xfer) state_d = S_SPC;
            S_SPC: begin
                if (xfer) begin
                    if (spc_q == SPC_LAST) begin
                        spc_d   = '0;
                        state_d = S_PFX;
                    end else begin
                        spc_d = spc_q + 1'b1;
                    end
                end
            end
            S_PFX: begin
                // A tens digit exists only from v10 upward; no leading zero.
                if (xfer) state_d = (tens_q != 4'd0) ? S_TENS : S_ONES;
            end
            S_TENS: if (xfer) state_d = S_ONES;
            S_ONES: begin
                if (xfer) state_d = last_id ? S_SEMI : S_COMMA;
            end
            S_COMMA: begin
                if (xfer) begin
                    idx_d = idx_q + 7'd1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                    state_d = S_PFX;
                end
            end
            S_SEMI: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            nvars_q <= 7'd0;
            idx_q   <= 7'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            spc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nvars_q <= nvars_d;
            idx_q   <= idx_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            spc_q   <= spc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The character is a pure function of the registered state, so it holds
    // steady for as long as the consumer stalls.
    always_comb begin
        out_char = 8'h00;
        case (state_q)
            S_KW_I:  out_char = 8'h69;
            S_KW_N:  out_char = 8'h6E;
            S_KW_T:  out_char = 8'h74;
            S_SPC:   out_char = 8'h20;
            S_PFX:   out_char = PREFIX;
            S_TENS:  out_char = {4'h3, tens_q};
            S_ONES:  out_char = {4'h3, ones_q};
            S_COMMA: out_char = 8'h2C;
            S_SEMI:  out_char = 8'h3B;
            default: out_char = 8'h00;
        endcase
    end

    assign out_valid = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_intdecl_gen.sv
module tb_intdecl_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, start3;
    logic [6:0] nv0, nv3;
    logic       ready0, ready3;
    logic [7:0] char0, char3;
    logic       valid0, valid3, busy0, busy3, done0, done3, err0, err3;

    intdecl_gen u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .nvars(nv0),
        .out_char(char0), .out_valid(valid0), .out_ready(ready0),
        .busy(busy0), .done(done0), .err(err0)
    );

    intdecl_gen #(.SEP_SPACES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .nvars(nv3),
        .out_char(char3), .out_valid(valid3), .out_ready(ready3),
        .busy(busy3), .done(done3), .err(err3)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb3[$];
    int xfer0 = 0, xfer3 = 0;
    int done_cnt0 = 0, done_cnt3 = 0;
    int rmode = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected character sequence for one declaration.
    task automatic push_exp(input int inst, input int n, input int sep);
        logic [7:0] s[$];
        s.push_back(8'h69); s.push_back(8'h6E); s.push_back(8'h74);
        for (int k = 0; k < sep; k++) s.push_back(8'h20);
        for (int i = 0; i < n; i++) begin
            s.push_back(8'h76);
            if (i >= 10) s.push_back(8'(48 + i / 10));
            s.push_back(8'(48 + i % 10));
            s.push_back((i < n - 1) ? 8'h2C : 8'h3B);
        end
        foreach (s[j]) begin
            if (inst == 0) sb0.push_back(s[j]);
            else           sb3.push_back(s[j]);
        end
    endtask

    // Monitor for the default instance.
    logic [7:0] prev_char0;
    logic       stall0 = 1'b0, semi0 = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            stall0 <= 1'b0;
            semi0  <= 1'b0;
        end else begin
            if (stall0) begin
                chk_eq("hold_valid0", valid0, 1);
                chk_eq("hold_char0", char0, prev_char0);
            end
            if (semi0) chk_eq("done_after_semi0", done0, 1);
            else if (done0) chk_eq("done_spurious0", done0, 0);
            if (done0) done_cnt0 <= done_cnt0 + 1;
            else chk_eq("busy_valid0", busy0, valid0);
            if (valid0 && ready0) begin
                chk_eq("sb0_nonempty", sb0.size() != 0, 1);
                if (sb0.size() != 0) chk_eq("char0", char0, sb0.pop_front());
                xfer0 <= xfer0 + 1;
            end
            stall0     <= valid0 && !ready0;
            prev_char0 <= char0;
            semi0      <= valid0 && ready0 && (char0 == 8'h3B);
        end
    end

    // Monitor for the SEP_SPACES=3 instance.
    logic semi3 = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            semi3 <= 1'b0;
        end else begin
            if (semi3) chk_eq("done_after_semi3", done3, 1);
            else if (done3) chk_eq("done_spurious3", done3, 0);
            if (done3) done_cnt3 <= done_cnt3 + 1;
            if (valid3 && ready3) begin
                chk_eq("sb3_nonempty", sb3.size() != 0, 1);
                if (sb3.size() != 0) chk_eq("char3", char3, sb3.pop_front());
                xfer3 <= xfer3 + 1;
            end
            semi3 <= valid3 && ready3 && (char3 == 8'h3B);
        end
    end

    // Consumer ready pattern: 0 = always, 1 = toggle, 2 = random.
    initial begin
        ready0 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       ready0 = ~ready0;
                2:       ready0 = 1'($urandom_range(0, 1));
                default: ready0 = 1'b1;
            endcase
        end
    end

    task automatic start0_decl(input int n);
        push_exp(0, n, 1);
        nv0    = 7'(n);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    // Returns just after the falling edge on which done is seen.
    task automatic wait_done(input int inst, input int maxc, output int c);
        c = 0;
        forever begin
            @(negedge clk);
            #1;
            if ((inst == 0) ? done0 : done3) break;
            c++;
            if (c >= maxc) begin
                chk_eq("timeout_done", (inst == 0) ? done0 : done3, 1);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dbase, c;
        reset  = 1'b0;
        start0 = 1'b0; nv0 = 7'd0;
        start3 = 1'b0; nv3 = 7'd0; ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_char", char0, 8'h00);
        chk_eq("rst_valid", valid0, 0);
        chk_eq("rst_busy", busy0, 0);
        chk_eq("rst_done", done0, 0);
        chk_eq("rst_err", err0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // nvars=3, ready always high
        rmode = 0;
        base  = xfer0;
        dbase = done_cnt0;
        start0_decl(3);
        @(negedge clk);
        #1;
        chk_eq("lat_valid", valid0, 1);
        chk_eq("lat_char", char0, 8'h69);
        wait_done(0, 40, c);
        chk_eq("t1_cycles", c, 12);
        chk_eq("t1_len", xfer0 - base, 13);
        chk_eq("t1_sb_empty", sb0.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t1_done_once", done_cnt0 - dbase, 1);
        chk_eq("t1_idle_valid", valid0, 0);

        // nvars=12 with toggling ready
        rmode = 1;
        base  = xfer0;
        start0_decl(12);
        wait_done(0, 200, c);
        chk_eq("t2_len", xfer0 - base, 42);
        chk_eq("t2_sb_empty", sb0.size(), 0);
        @(posedge clk);
        #1;
        rmode = 0;

        // illegal counts
        nv0 = 7'd0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk_eq("t3_err_zero", err0, 1);
        chk_eq("t3_valid_zero", valid0, 0);
        chk_eq("t3_busy_zero", busy0, 0);
        @(posedge clk);
        #1;
        chk_eq("t3_err_pulse", err0, 0);
        nv0 = 7'd17; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        chk_eq("t3_err_big", err0, 1);
        chk_eq("t3_valid_big", valid0, 0);
        chk_eq("t3_busy_big", busy0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("t3_still_idle", valid0, 0);

        // SEP_SPACES=3, nvars=1, start pulsed while busy
        base = xfer3;
        push_exp(3, 1, 3);
        nv3 = 7'd1; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("t4_busy", busy3, 1);
        nv3 = 7'd5; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        wait_done(3, 40, c);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("t4_len", xfer3 - base, 9);
        chk_eq("t4_sb_empty", sb3.size(), 0);
        chk_eq("t4_no_restart", valid3, 0);
        chk_eq("t4_done_once", done_cnt3, 1);

        // reset mid-stream after "int v"
        rmode = 0;
        base  = xfer0;
        start0_decl(3);
        c = 0;
        while ((xfer0 - base < 5) && (c < 50)) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk_eq("t5_reached", xfer0 - base, 5);
        reset = 1'b0;
        #1;
        chk_eq("t5_valid_drop", valid0, 0);
        chk_eq("t5_busy_drop", busy0, 0);
        sb0.delete();
        dbase = done_cnt0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t5_no_done", done_cnt0 - dbase, 0);
        chk_eq("t5_idle", valid0, 0);
        base = xfer0;
        start0_decl(3);
        wait_done(0, 40, c);
        chk_eq("t5_full_len", xfer0 - base, 13);
        chk_eq("t5_sb_empty", sb0.size(), 0);
        @(posedge clk);
        #1;

        // every count 1..16, random ready, back-to-back starts on done
        rmode = 2;
        dbase = done_cnt0;
        start0_decl(1);
        for (int n = 2; n <= 16; n++) begin
            wait_done(0, 600, c);
            push_exp(0, n, 1);
            nv0    = 7'(n);
            start0 = 1'b1;
            @(posedge clk);
            #1 start0 = 1'b0;
        end
        wait_done(0, 600, c);
        @(posedge clk);
        #1;
        rmode = 0;
        chk_eq("t6_done_count", done_cnt0 - dbase, 16);
        chk_eq("t6_sb_empty", sb0.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t6_idle", valid0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
